// File: rtl/chip8_pkg.sv
// chip8_pkg: shared arbiter constants, FSM state encoding and default widths
package chip8_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 8;
  localparam int LOCK_LIMIT = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU/GPU request ports and single-port memory bus of the arbiter
interface mem_arbiter_if import chip8_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          cpu_req, gpu_req;
  logic          cpu_we, gpu_we;
  logic [AW-1:0] cpu_idx, gpu_idx;
  logic [DW-1:0] cpu_wbyte, gpu_wbyte;
  logic          gpu_lock;
  logic          cpu_ack, gpu_ack;
  logic [DW-1:0] rbyte;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_idx;
  logic [DW-1:0] mem_wbyte;
  logic [DW-1:0] mem_rbyte;
  modport slave (
    input  cpu_req, gpu_req, cpu_we, gpu_we, cpu_idx, gpu_idx,
           cpu_wbyte, gpu_wbyte, gpu_lock, mem_rbyte,
    output cpu_ack, gpu_ack, rbyte, mem_en, mem_we, mem_idx, mem_wbyte
  );
  modport master (
    output cpu_req, gpu_req, cpu_we, gpu_we, cpu_idx, gpu_idx,
           cpu_wbyte, gpu_wbyte, gpu_lock, mem_rbyte,
    input  cpu_ack, gpu_ack, rbyte, mem_en, mem_we, mem_idx, mem_wbyte
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/GPU memory arbiter, 3-cycle access, round-robin with GPU burst lock (MEM_ARBITER_FIXED_PRIO_EN: CPU-first priority)
module mem_arbiter import chip8_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  arb_state_t state, state_nx;
  logic last_gpu, last_gpu_nx, win_gpu, win_gpu_nx, lat_we, lat_we_nx;
  logic [AW-1:0] lat_idx, lat_idx_nx;
  logic [DW-1:0] lat_wbyte, lat_wbyte_nx;
  logic [4:0] lock_cnt, lock_cnt_nx;
  logic lock_hold, cpu_ok, gpu_win, grant;
  // state and latched access fields; last grant starts as GPU so CPU wins first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last_gpu  <= 1'b1;
      win_gpu   <= 1'b0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wbyte <= '0;
      lock_cnt  <= '0;
    end else begin
      state     <= state_nx;
      last_gpu  <= last_gpu_nx;
      win_gpu   <= win_gpu_nx;
      lat_we    <= lat_we_nx;
      lat_idx   <= lat_idx_nx;
      lat_wbyte <= lat_wbyte_nx;
      lock_cnt  <= lock_cnt_nx;
    end
  // arbitration in IDLE; lock blocks CPU only after a real GPU grant and until the burst limit
  always_comb begin
    lock_hold    = bus.gpu_lock && last_gpu && lock_cnt != '0 && lock_cnt < 5'(LOCK_LIMIT);
    cpu_ok       = bus.cpu_req && !lock_hold;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    gpu_win      = bus.gpu_req && !cpu_ok;
`else
    gpu_win      = bus.gpu_req && !(cpu_ok && last_gpu);
`endif
    grant        = cpu_ok || bus.gpu_req;
    state_nx     = state;
    last_gpu_nx  = last_gpu;
    win_gpu_nx   = win_gpu;
    lat_we_nx    = lat_we;
    lat_idx_nx   = lat_idx;
    lat_wbyte_nx = lat_wbyte;
    lock_cnt_nx  = bus.gpu_lock ? lock_cnt : '0;
    case (state)
      IDLE: if (grant) begin
        state_nx     = ISSUE;
        last_gpu_nx  = gpu_win;
        win_gpu_nx   = gpu_win;
        lat_we_nx    = gpu_win ? bus.gpu_we : bus.cpu_we;
        lat_idx_nx   = gpu_win ? bus.gpu_idx : bus.cpu_idx;
        lat_wbyte_nx = gpu_win ? bus.gpu_wbyte : bus.cpu_wbyte;
        lock_cnt_nx  = !(gpu_win && bus.gpu_lock) ? '0 :
                       lock_cnt == 5'(LOCK_LIMIT) ? lock_cnt : lock_cnt + 5'd1;
      end
      ISSUE: state_nx = ACK;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.mem_en    = state == ISSUE;
  assign bus.mem_we    = state == ISSUE && lat_we;
  assign bus.mem_idx   = lat_idx;
  assign bus.mem_wbyte = lat_wbyte;
  assign bus.cpu_ack   = state == ACK && !win_gpu;
  assign bus.gpu_ack   = state == ACK && win_gpu;
  assign bus.rbyte     = state == ACK ? bus.mem_rbyte : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a grant/memory reference model
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    logic gpu, we;
    logic [AW-1:0] idx, cidx, gidx;
    logic [DW-1:0] wb, rb, cwb, gwb;
    logic cwe, gwe;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int failed = 0;
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] ref_mem [4096];
  logic m_last_gpu = 1'b1;
  logic prev_en = 1'b0;
  rec_t recs[$];
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // synchronous memory with registered read data
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_idx] = bus.mem_wbyte;
      else bus.mem_rbyte <= mem[bus.mem_idx];
    end
  // protocol watch: exclusive acks, one-cycle strobe, ack exactly one cycle after strobe
  always @(negedge clk)
    if (rst_n) begin
      if (bus.cpu_ack && bus.gpu_ack) begin
        tests++; failed++;
        $display("FAIL ack_exclusive: cpu_ack=1 gpu_ack=1, required at most one");
      end
      if ((bus.cpu_ack || bus.gpu_ack) !== prev_en) begin
        tests++; failed++;
        $display("FAIL ack_timing: ack=%0b, required %0b", bus.cpu_ack || bus.gpu_ack, prev_en);
      end
      if (bus.mem_en && prev_en) begin
        tests++; failed++;
        $display("FAIL strobe_len: mem_en high two cycles, required one");
      end
      prev_en = bus.mem_en;
    end else prev_en = 1'b0;
  // round-robin reference: on contention the requester not granted most recently wins
  function automatic logic pick(input logic c, input logic g);
    logic w;
    if (c && g) w = FIXED ? 1'b0 : !m_last_gpu;
    else w = g;
    m_last_gpu = w;
    return w;
  endfunction
  task automatic scramble(input logic wr);
    bus.cpu_idx   = 12'($urandom);
    bus.gpu_idx   = 12'($urandom);
    bus.cpu_wbyte = 8'($urandom);
    bus.gpu_wbyte = 8'($urandom);
    bus.cpu_we    = wr & 1'($urandom);
    bus.gpu_we    = wr & 1'($urandom);
  endtask
  task automatic do_reset();
    bus.cpu_req = 1'b0; bus.gpu_req = 1'b0; bus.gpu_lock = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last_gpu = 1'b1;
    @(negedge clk);
  endtask
  task automatic access(input logic g, input logic we, input logic [AW-1:0] idx, input logic [DW-1:0] wb,
                        output logic ok, output logic [DW-1:0] rb, output logic who);
    int t;
    if (g) begin bus.gpu_we = we; bus.gpu_idx = idx; bus.gpu_wbyte = wb; bus.gpu_req = 1'b1; end
    else begin bus.cpu_we = we; bus.cpu_idx = idx; bus.cpu_wbyte = wb; bus.cpu_req = 1'b1; end
    t = 0;
    @(negedge clk);
    while (!(bus.cpu_ack || bus.gpu_ack) && t < 20) begin @(negedge clk); t++; end
    ok = bus.cpu_ack || bus.gpu_ack;
    rb = bus.rbyte;
    who = bus.gpu_ack;
    bus.cpu_req = 1'b0; bus.gpu_req = 1'b0;
  endtask
  task automatic burst(input int n, input logic c, input logic g, input logic lk, input logic wr);
    rec_t r;
    int t;
    recs.delete();
    scramble(wr);
    bus.gpu_lock = lk; bus.cpu_req = c; bus.gpu_req = g;
    for (int k = 0; k < n; k++) begin
      t = 0;
      @(negedge clk);
      while (!bus.mem_en && t < 20) begin @(negedge clk); t++; end
      if (!bus.mem_en) begin
        tests++; failed++;
        $display("FAIL burst_timeout: access %0d mem_en=0 after 20 cycles, required 1", k);
        break;
      end
      r.cwe = bus.cpu_we; r.cidx = bus.cpu_idx; r.cwb = bus.cpu_wbyte;
      r.gwe = bus.gpu_we; r.gidx = bus.gpu_idx; r.gwb = bus.gpu_wbyte;
      r.we = bus.mem_we; r.idx = bus.mem_idx; r.wb = bus.mem_wbyte;
      scramble(wr);
      @(negedge clk);
      r.gpu = bus.gpu_ack;
      r.rb = bus.rbyte;
      if (k == n - 1) begin bus.cpu_req = 1'b0; bus.gpu_req = 1'b0; end
      recs.push_back(r);
    end
    bus.cpu_req = 1'b0; bus.gpu_req = 1'b0;
  endtask
  task automatic test_reset();
    bus.cpu_req = 1'b0; bus.gpu_req = 1'b0; bus.gpu_lock = 1'b0;
    bus.cpu_we = 1'b0; bus.gpu_we = 1'b0;
    bus.cpu_idx = '0; bus.gpu_idx = '0; bus.cpu_wbyte = '0; bus.gpu_wbyte = '0;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.cpu_ack, bus.gpu_ack, bus.mem_en, bus.mem_we} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_ctrl: ack/en/we=%b, required 0000", {bus.cpu_ack, bus.gpu_ack, bus.mem_en, bus.mem_we});
    end
    tests++;
    if ({bus.mem_idx, bus.mem_wbyte, bus.rbyte} !== 28'h0) begin
      failed++;
      $display("FAIL reset_data: idx=%h wbyte=%h rbyte=%h, required 0", bus.mem_idx, bus.mem_wbyte, bus.rbyte);
    end
    do_reset();
    tests++;
    if ({bus.cpu_ack, bus.gpu_ack, bus.mem_en} !== 3'b000) begin
      failed++;
      $display("FAIL reset_idle: ack/en=%b with no request, required 000", {bus.cpu_ack, bus.gpu_ack, bus.mem_en});
    end
  endtask
  task automatic test_single_read();
    do_reset();
    mem[12'h200] = 8'hA2; ref_mem[12'h200] = 8'hA2;
    bus.cpu_we = 1'b0; bus.cpu_idx = 12'h200; bus.cpu_req = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.gpu_ack} !== 4'b1000 || bus.mem_idx !== 12'h200) begin
      failed++;
      $display("FAIL single_issue: en/we/acks=%b idx=%h, required 1000 idx=200",
               {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.gpu_ack}, bus.mem_idx);
    end
    @(negedge clk);
    tests++;
    if ({bus.mem_en, bus.cpu_ack, bus.gpu_ack} !== 3'b010) begin
      failed++;
      $display("FAIL single_ack: en/cpu_ack/gpu_ack=%b, required 010", {bus.mem_en, bus.cpu_ack, bus.gpu_ack});
    end
    tests++;
    if (bus.rbyte !== 8'hA2) begin
      failed++;
      $display("FAIL single_rbyte: rbyte=%h, required a2", bus.rbyte);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_alternate();
    logic exp;
    do_reset();
    burst(4, 1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (recs.size() !== 4) begin
      failed++;
      $display("FAIL alt_count: %0d accesses, required 4", recs.size());
    end
    foreach (recs[k]) begin
      exp = FIXED ? 1'b0 : (k % 2 == 1);
      tests++;
      if (recs[k].gpu !== exp) begin
        failed++;
        $display("FAIL alt_grant: access %0d gpu=%0b, required %0b", k, recs[k].gpu, exp);
      end
      tests++;
      if (recs[k].rb !== ref_mem[exp ? recs[k].gidx : recs[k].cidx]) begin
        failed++;
        $display("FAIL alt_rbyte: access %0d rbyte=%h, required %h", k, recs[k].rb, ref_mem[exp ? recs[k].gidx : recs[k].cidx]);
      end
    end
  endtask
  task automatic test_write_read();
    logic ok, who;
    logic [DW-1:0] rb;
    access(1'b1, 1'b1, 12'hF00, 8'h3C, ok, rb, who);
    ref_mem[12'hF00] = 8'h3C;
    tests++;
    if ({ok, who} !== 2'b11) begin
      failed++;
      $display("FAIL wr_gpu: ok/gpu=%b, required 11", {ok, who});
    end
    access(1'b0, 1'b0, 12'hF00, 8'h00, ok, rb, who);
    tests++;
    if ({ok, who} !== 2'b10 || rb !== 8'h3C) begin
      failed++;
      $display("FAIL wr_readback: ok/gpu=%b rbyte=%h, required 10 rbyte=3c", {ok, who}, rb);
    end
  endtask
  task automatic test_lock();
    logic ok, who;
    logic [DW-1:0] rb;
    int gcnt;
    do_reset();
    bus.gpu_lock = 1'b1;
    access(1'b1, 1'b0, 12'($urandom), 8'h00, ok, rb, who);
    gcnt = (ok && who) ? 1 : 0;
    tests++;
    if ({ok, who} !== 2'b11) begin
      failed++;
      $display("FAIL lock_first: ok/gpu=%b, required 11", {ok, who});
    end
    burst(16, 1'b1, 1'b1, 1'b1, 1'b0);
    foreach (recs[k]) begin
      gcnt += recs[k].gpu ? 1 : 0;
      tests++;
      if (recs[k].gpu !== (k < 15)) begin
        failed++;
        $display("FAIL lock_grant: access %0d gpu=%0b, required %0b", k + 1, recs[k].gpu, k < 15);
      end
    end
    tests++;
    if (gcnt !== 16 || recs.size() !== 16) begin
      failed++;
      $display("FAIL lock_total: %0d gpu grants in %0d accesses, required 16 then one cpu", gcnt, recs.size() + 1);
    end
    bus.gpu_lock = 1'b0;
  endtask
  task automatic test_reset_issue();
    logic ok, who;
    logic [DW-1:0] rb;
    logic [AW-1:0] a;
    do_reset();
    bus.cpu_we = 1'b0; bus.cpu_idx = 12'($urandom); bus.cpu_req = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.mem_en !== 1'b1) begin
      failed++;
      $display("FAIL rst_issue_setup: mem_en=%b, required 1", bus.mem_en);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.cpu_ack, bus.gpu_ack, bus.mem_en, bus.mem_we, bus.mem_idx, bus.mem_wbyte, bus.rbyte} !== 32'h0) begin
      failed++;
      $display("FAIL rst_issue_out: en=%b idx=%h acks=%b, required all 0", bus.mem_en, bus.mem_idx, {bus.cpu_ack, bus.gpu_ack});
    end
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.cpu_ack, bus.gpu_ack} !== 2'b00) begin
        failed++;
        $display("FAIL rst_issue_noack: acks=%b, required 00", {bus.cpu_ack, bus.gpu_ack});
      end
    end
    rst_n = 1'b1;
    m_last_gpu = 1'b1;
    @(negedge clk);
    a = 12'($urandom);
    access(1'b0, 1'b0, a, 8'h00, ok, rb, who);
    tests++;
    if ({ok, who} !== 2'b10 || rb !== ref_mem[a]) begin
      failed++;
      $display("FAIL rst_issue_after: ok/gpu=%b rbyte=%h, required 10 rbyte=%h", {ok, who}, rb, ref_mem[a]);
    end
  endtask
  task automatic test_random();
    logic c, g, w, pwe;
    logic [AW-1:0] pidx;
    logic [DW-1:0] pwb;
    int n;
    do_reset();
    for (int b = 0; b < 8; b++) begin
      c = 1'($urandom);
      g = c ? 1'($urandom) : 1'b1;
      n = $urandom_range(2, 6);
      burst(n, c, g, 1'b0, 1'b1);
      tests++;
      if (recs.size() !== n) begin
        failed++;
        $display("FAIL rnd_count: burst %0d had %0d accesses, required %0d", b, recs.size(), n);
      end
      foreach (recs[k]) begin
        w = pick(c, g);
        pwe  = w ? recs[k].gwe : recs[k].cwe;
        pidx = w ? recs[k].gidx : recs[k].cidx;
        pwb  = w ? recs[k].gwb : recs[k].cwb;
        tests++;
        if (recs[k].gpu !== w) begin
          failed++;
          $display("FAIL rnd_grant: burst %0d access %0d gpu=%0b, required %0b", b, k, recs[k].gpu, w);
        end
        tests++;
        if (recs[k].we !== pwe || recs[k].idx !== pidx || (pwe && recs[k].wb !== pwb)) begin
          failed++;
          $display("FAIL rnd_fields: burst %0d access %0d we/idx/wb=%b/%h/%h, required %b/%h/%h",
                   b, k, recs[k].we, recs[k].idx, recs[k].wb, pwe, pidx, pwb);
        end
        if (pwe) ref_mem[pidx] = pwb;
        else begin
          tests++;
          if (recs[k].rb !== ref_mem[pidx]) begin
            failed++;
            $display("FAIL rnd_rbyte: burst %0d access %0d rbyte=%h, required %h", b, k, recs[k].rb, ref_mem[pidx]);
          end
        end
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_lock();
    test_reset_issue();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
